decode_stage: RTL and testbench
===============================

DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 Parameters SHALL be (name, default, meaning): INSTR_W, 20, instruction width; DATA_W, 19, register/data width; PC_W, 15, PC width; NREGS, 19, architectural registers; REG_AW, 5, register address width (2**REG_AW >= NREGS).
REQ-002 Ports SHALL be (name direction width meaning): clk in 1 clock; reset in 1 synchronous active-high reset; StallE in 1 hold ID/EX register; FlushE in 1 insert bubble into ID/EX.
REQ-003 Ports SHALL include: InstrD in INSTR_W decode-stage instruction; PCD in PC_W decode-stage PC; RegWriteW in 1 writeback enable; RdW in REG_AW writeback destination; ResultW in DATA_W writeback data.
REQ-004 Outputs SHALL be: RegWriteE, MemWriteE, JumpE, ALUSrcE, Cant_ByteE, IllegalE (1 each); BranchE 2; ResultSrcE 2; ALUControlE 3; RD1E, RD2E, ImmExtE DATA_W; PCE PC_W; RS1E, RS2E, RDE REG_AW.

Function
REQ-005 Fields SHALL be: opcode InstrD[4:0], rd [9:5], rs1 [14:10], rs2 [19:15], imm InstrD[INSTR_W-1:10] sign-extended to DATA_W.
REQ-006 Opcodes SHALL decode (RegWrite/MemWrite/ALUSrc/ResultSrc/Branch/Jump/ALUControl/Cant_Byte): ADD 00h 1/0/0/00/00/0/000/0; SUB 01h …/001; AND 02h …/010; OR 03h …/011.
REQ-007 Further opcodes: ADDI 04h 1/0/1/00/00/0/000/0; LD 05h 1/0/1/01/00/0/000/0; ST 06h 0/1/1/00/00/0/000/0; LDB 0Ah as LD with Cant_Byte=1; STB 0Bh as ST with Cant_Byte=1.
REQ-008 Control opcodes: BEQ 07h 0/0/0/00/01/0/001/0; BNE 08h branch=10, else as BEQ; JMP 09h 0/0/0/10/00/1/000/0; NOP 1Fh all zero.
REQ-009 Any other opcode SHALL decode as NOP with IllegalE=1 in EX.
REQ-010 Register file SHALL hold NREGS entries of DATA_W; register 0 reads zero, writes to it ignored.
REQ-011 Write SHALL occur on rising clk when RegWriteW=1, RdW!=0 and RdW<NREGS; RdW>=NREGS SHALL be ignored.
REQ-012 Reads SHALL be combinational; rs>=NREGS SHALL read zero.
REQ-013 Same-cycle bypass: RegWriteW=1, RdW==rs, rs!=0, rs<NREGS SHALL return ResultW instead of the stored value.
REQ-014 ID/EX register SHALL capture all decoded controls, RD1, RD2, ImmExt, PCD, rs1, rs2, rd on rising clk; latency exactly 1 cycle.
REQ-015 Priority SHALL be reset > FlushE > StallE > load.
REQ-016 FlushE=1 SHALL load a bubble: all control outputs and IllegalE 0, data/address outputs 0.
REQ-017 StallE=1 (FlushE=0) SHALL hold every E output unchanged; register-file writes SHALL still occur.
REQ-018 RS1E/RS2E SHALL be registered source addresses for the external hazard unit; rs fields of non-reading opcodes still pass through.

Reset
REQ-019 With reset=1 at rising clk, all E outputs SHALL become 0 and all register-file entries 0 on that edge.
REQ-020 Reset asserted mid-stall or coincident with RegWriteW SHALL win; no write occurs that cycle.
REQ-021 First valid decode SHALL appear on E outputs one cycle after reset deasserts.

Structure
REQ-022 Package decode_pkg SHALL hold the opcode enum, ALUControl encodings, ResultSrc/Branch encodings and the control-bundle struct.
REQ-023 Register file SHALL be sub-module reg_file (parametrised NREGS, DATA_W, REG_AW, bypass included); decode table and ID/EX register stay in decode_stage.

Verification
REQ-024 Write R5=05h, next cycle InstrD ADD rd=3 rs1=5 rs2=0 -> one cycle later RD1E=05h, RD2E=0, RegWriteE=1, ALUControlE=000, RDE=3.
REQ-025 RegWriteW=1 RdW=7 ResultW=1234h same cycle as SUB rs1=7 -> RD1E=1234h (bypass), ALUControlE=001.
REQ-026 ADDI imm=3FFh -> ImmExtE=7FFFFh, ALUSrcE=1; LDB -> ResultSrcE=01, Cant_ByteE=1.
REQ-027 Load BEQ, then StallE=1 two cycles with new InstrD -> E outputs unchanged; FlushE=1 together with StallE -> all controls 0.
REQ-028 Opcode 1Eh -> IllegalE=1, RegWriteE=0; write RdW=0 then read rs1=0 -> RD1E=0; RdW=20 ignored.
REQ-029 reset=1 with RegWriteW=1 RdW=4 -> outputs 0, later read of R4 returns 0.

Source files
------------

// File: rtl/decode_pkg.sv
// rtl/decode_pkg.sv - opcode, ALU/result/branch encodings and control bundle for decode_stage
package decode_pkg;

  typedef enum logic [4:0] {
    OP_ADD  = 5'h00,
    OP_SUB  = 5'h01,
    OP_AND  = 5'h02,
    OP_OR   = 5'h03,
    OP_ADDI = 5'h04,
    OP_LD   = 5'h05,
    OP_ST   = 5'h06,
    OP_BEQ  = 5'h07,
    OP_BNE  = 5'h08,
    OP_JMP  = 5'h09,
    OP_LDB  = 5'h0A,
    OP_STB  = 5'h0B,
    OP_NOP  = 5'h1F
  } opcode_e;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011
  } alu_ctrl_e;

  typedef enum logic [1:0] {
    RES_ALU = 2'b00,
    RES_MEM = 2'b01,
    RES_PC  = 2'b10
  } result_src_e;

  typedef enum logic [1:0] {
    BR_NONE = 2'b00,
    BR_EQ   = 2'b01,
    BR_NE   = 2'b10
  } branch_e;

  typedef struct packed {
    logic        reg_write;
    logic        mem_write;
    logic        jump;
    logic        alu_src;
    logic        cant_byte;
    logic        illegal;
    branch_e     branch;
    result_src_e result_src;
    alu_ctrl_e   alu_ctrl;
  } ctrl_t;

  // Unknown opcodes behave as NOP but raise illegal so EX can trap.
  function automatic ctrl_t decode_op(input logic [4:0] op);
    ctrl_t c;
    c = '0;
    case (op)
      OP_ADD:  c.reg_write = 1'b1;
      OP_SUB:  begin c.reg_write = 1'b1; c.alu_ctrl = ALU_SUB; end
      OP_AND:  begin c.reg_write = 1'b1; c.alu_ctrl = ALU_AND; end
      OP_OR:   begin c.reg_write = 1'b1; c.alu_ctrl = ALU_OR;  end
      OP_ADDI: begin c.reg_write = 1'b1; c.alu_src = 1'b1; end
      OP_LD:   begin c.reg_write = 1'b1; c.alu_src = 1'b1; c.result_src = RES_MEM; end
      OP_ST:   begin c.mem_write = 1'b1; c.alu_src = 1'b1; end
      OP_LDB:  begin
        c.reg_write = 1'b1; c.alu_src = 1'b1; c.result_src = RES_MEM; c.cant_byte = 1'b1;
      end
      OP_STB:  begin c.mem_write = 1'b1; c.alu_src = 1'b1; c.cant_byte = 1'b1; end
      OP_BEQ:  begin c.branch = BR_EQ; c.alu_ctrl = ALU_SUB; end
      OP_BNE:  begin c.branch = BR_NE; c.alu_ctrl = ALU_SUB; end
      OP_JMP:  begin c.jump = 1'b1; c.result_src = RES_PC; end
      OP_NOP:  c = '0;
      default: c.illegal = 1'b1;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/decode_stage_if.sv
// rtl/decode_stage_if.sv - ID/EX pipeline register outputs handed to the execute stage
interface decode_stage_if #(
  parameter int DATA_W = 19,
  parameter int PC_W   = 15,
  parameter int REG_AW = 5
);
  logic              RegWriteE, MemWriteE, JumpE, ALUSrcE, Cant_ByteE, IllegalE;
  logic [1:0]        BranchE;
  logic [1:0]        ResultSrcE;
  logic [2:0]        ALUControlE;
  logic [DATA_W-1:0] RD1E, RD2E, ImmExtE;
  logic [PC_W-1:0]   PCE;
  logic [REG_AW-1:0] RS1E, RS2E, RDE;

  modport master (
    output RegWriteE, MemWriteE, JumpE, ALUSrcE, Cant_ByteE, IllegalE,
           BranchE, ResultSrcE, ALUControlE, RD1E, RD2E, ImmExtE, PCE, RS1E, RS2E, RDE
  );
  modport slave (
    input  RegWriteE, MemWriteE, JumpE, ALUSrcE, Cant_ByteE, IllegalE,
           BranchE, ResultSrcE, ALUControlE, RD1E, RD2E, ImmExtE, PCE, RS1E, RS2E, RDE
  );
endinterface

// File: rtl/reg_file.sv
// rtl/reg_file.sv - register file, r0 hardwired to zero, writeback bypass on reads
module reg_file #(
  parameter int NREGS  = 19,
  parameter int DATA_W = 19,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [REG_AW-1:0] wa,
  input  logic [DATA_W-1:0] wd,
  input  logic [REG_AW-1:0] ra1,
  input  logic [REG_AW-1:0] ra2,
  output logic [DATA_W-1:0] rd1,
  output logic [DATA_W-1:0] rd2
);

  localparam logic [REG_AW:0] NREGS_L = (REG_AW+1)'(NREGS);

  logic [DATA_W-1:0] regs [NREGS];

  function automatic logic valid_addr(input logic [REG_AW-1:0] a);
    return (a != '0) && ({1'b0, a} < NREGS_L);
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (we && valid_addr(wa)) begin
      regs[wa] <= wd;
    end
  end

  // Writeback lands at the same edge ID/EX samples, so forward it.
  always_comb begin
    rd1 = '0;
    rd2 = '0;
    if (valid_addr(ra1)) rd1 = (we && wa == ra1) ? wd : regs[ra1];
    if (valid_addr(ra2)) rd2 = (we && wa == ra2) ? wd : regs[ra2];
  end

endmodule

// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - instruction decode, register read and ID/EX pipeline register
module decode_stage
  import decode_pkg::*;
#(
  parameter int INSTR_W = 20,
  parameter int DATA_W  = 19,
  parameter int PC_W    = 15,
  parameter int NREGS   = 19,
  parameter int REG_AW  = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               StallE,
  input  logic               FlushE,
  input  logic [INSTR_W-1:0] InstrD,
  input  logic [PC_W-1:0]    PCD,
  input  logic               RegWriteW,
  input  logic [REG_AW-1:0]  RdW,
  input  logic [DATA_W-1:0]  ResultW,
  decode_stage_if.master     ex
);

  localparam int IMM_W = INSTR_W - 10;

  logic [REG_AW-1:0] rd_d, rs1_d, rs2_d;
  logic [DATA_W-1:0] rd1_d, rd2_d, imm_d;
  ctrl_t             ctrl_d;

  assign rd_d   = InstrD[5 +: REG_AW];
  assign rs1_d  = InstrD[10 +: REG_AW];
  assign rs2_d  = InstrD[15 +: REG_AW];
  assign imm_d  = {{(DATA_W-IMM_W){InstrD[INSTR_W-1]}}, InstrD[INSTR_W-1:10]};
  assign ctrl_d = decode_op(InstrD[4:0]);

  reg_file #(.NREGS(NREGS), .DATA_W(DATA_W), .REG_AW(REG_AW)) u_reg_file (
    .clk   (clk),
    .reset (reset),
    .we    (RegWriteW),
    .wa    (RdW),
    .wd    (ResultW),
    .ra1   (rs1_d),
    .ra2   (rs2_d),
    .rd1   (rd1_d),
    .rd2   (rd2_d)
  );

  ctrl_t             ctrl_e;
  logic [DATA_W-1:0] rd1_e, rd2_e, imm_e;
  logic [PC_W-1:0]   pc_e;
  logic [REG_AW-1:0] rs1_e, rs2_e, rd_e;

  always_ff @(posedge clk) begin
    if (reset || FlushE) begin
      ctrl_e <= '0;
      rd1_e  <= '0;
      rd2_e  <= '0;
      imm_e  <= '0;
      pc_e   <= '0;
      rs1_e  <= '0;
      rs2_e  <= '0;
      rd_e   <= '0;
    end else if (!StallE) begin
      ctrl_e <= ctrl_d;
      rd1_e  <= rd1_d;
      rd2_e  <= rd2_d;
      imm_e  <= imm_d;
      pc_e   <= PCD;
      rs1_e  <= rs1_d;
      rs2_e  <= rs2_d;
      rd_e   <= rd_d;
    end
  end

  assign ex.RegWriteE   = ctrl_e.reg_write;
  assign ex.MemWriteE   = ctrl_e.mem_write;
  assign ex.JumpE       = ctrl_e.jump;
  assign ex.ALUSrcE     = ctrl_e.alu_src;
  assign ex.Cant_ByteE  = ctrl_e.cant_byte;
  assign ex.IllegalE    = ctrl_e.illegal;
  assign ex.BranchE     = ctrl_e.branch;
  assign ex.ResultSrcE  = ctrl_e.result_src;
  assign ex.ALUControlE = ctrl_e.alu_ctrl;
  assign ex.RD1E        = rd1_e;
  assign ex.RD2E        = rd2_e;
  assign ex.ImmExtE     = imm_e;
  assign ex.PCE         = pc_e;
  assign ex.RS1E        = rs1_e;
  assign ex.RS2E        = rs2_e;
  assign ex.RDE         = rd_e;

endmodule

// File: tb/tb_decode_stage.sv
// tb/tb_decode_stage.sv - scoreboard bench for decode_stage against a table-driven model
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        reset, StallE, FlushE, RegWriteW;
  logic [19:0] InstrD;
  logic [14:0] PCD;
  logic [4:0]  RdW;
  logic [18:0] ResultW;

  always #5 clk = ~clk;

  decode_stage_if #(.DATA_W(19), .PC_W(15), .REG_AW(5)) ex_if ();

  decode_stage dut (
    .clk(clk), .reset(reset), .StallE(StallE), .FlushE(FlushE),
    .InstrD(InstrD), .PCD(PCD), .RegWriteW(RegWriteW), .RdW(RdW),
    .ResultW(ResultW), .ex(ex_if)
  );

  // ctl = {illegal, RegWrite, MemWrite, ALUSrc, ResultSrc[1:0], Branch[1:0], Jump, ALUControl[2:0], Cant_Byte}
  typedef struct packed {
    logic [12:0] ctl;
    logic [18:0] rd1, rd2, imm;
    logic [14:0] pc;
    logic [4:0]  rs1, rs2, rd;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        cur;
  logic [18:0] mem [32];
  int          checks = 0;
  int          errors = 0;

  function automatic logic [12:0] ctl_of(input logic [4:0] op);
    case (op)
      5'h00:   return 13'b0_1_0_0_00_00_0_000_0;
      5'h01:   return 13'b0_1_0_0_00_00_0_001_0;
      5'h02:   return 13'b0_1_0_0_00_00_0_010_0;
      5'h03:   return 13'b0_1_0_0_00_00_0_011_0;
      5'h04:   return 13'b0_1_0_1_00_00_0_000_0;
      5'h05:   return 13'b0_1_0_1_01_00_0_000_0;
      5'h06:   return 13'b0_0_1_1_00_00_0_000_0;
      5'h07:   return 13'b0_0_0_0_00_01_0_001_0;
      5'h08:   return 13'b0_0_0_0_00_10_0_001_0;
      5'h09:   return 13'b0_0_0_0_10_00_1_000_0;
      5'h0A:   return 13'b0_1_0_1_01_00_0_000_1;
      5'h0B:   return 13'b0_0_1_1_00_00_0_000_1;
      5'h1F:   return 13'b0;
      default: return 13'b1_0_0_0_00_00_0_000_0;
    endcase
  endfunction

  function automatic logic [18:0] read_model(input logic [4:0] a);
    if (a == 0 || a >= 19) return 19'd0;
    if (RegWriteW && RdW == a) return ResultW;
    return mem[a];
  endfunction

  function automatic logic [19:0] mk(input logic [4:0] op, rd, rs1, rs2);
    return {rs2, rs1, rd, op};
  endfunction

  // One clock edge: predict what the ID/EX register holds after it.
  task automatic cycle();
    exp_t nxt;
    @(posedge clk);
    nxt.ctl = ctl_of(InstrD[4:0]);
    nxt.rd1 = read_model(InstrD[14:10]);
    nxt.rd2 = read_model(InstrD[19:15]);
    nxt.imm = 19'($signed(InstrD[19:10]));
    nxt.pc  = PCD;
    nxt.rs1 = InstrD[14:10];
    nxt.rs2 = InstrD[19:15];
    nxt.rd  = InstrD[9:5];
    if (reset) begin
      cur = '0;
      for (int i = 0; i < 32; i++) mem[i] = '0;
    end else begin
      if (FlushE) cur = '0;
      else if (!StallE) cur = nxt;
      if (RegWriteW && RdW != 0 && RdW < 19) mem[RdW] = ResultW;
    end
    sb_q.push_back(cur);
    #1;
  endtask

  task automatic set_in(input logic rst, st, fl, input logic [19:0] ins,
                        input logic we, input logic [4:0] wa, input logic [18:0] wd);
    reset = rst; StallE = st; FlushE = fl; InstrD = ins;
    PCD = 15'($urandom); RegWriteW = we; RdW = wa; ResultW = wd;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      exp_t e;
      logic [12:0] a;
      e = sb_q.pop_front();
      a = {ex_if.IllegalE, ex_if.RegWriteE, ex_if.MemWriteE, ex_if.ALUSrcE, ex_if.ResultSrcE,
           ex_if.BranchE, ex_if.JumpE, ex_if.ALUControlE, ex_if.Cant_ByteE};
      chk("controls", 32'(a), 32'(e.ctl));
      chk("RD1E", 32'(ex_if.RD1E), 32'(e.rd1));
      chk("RD2E", 32'(ex_if.RD2E), 32'(e.rd2));
      chk("ImmExtE", 32'(ex_if.ImmExtE), 32'(e.imm));
      chk("PCE", 32'(ex_if.PCE), 32'(e.pc));
      chk("RS1E", 32'(ex_if.RS1E), 32'(e.rs1));
      chk("RS2E", 32'(ex_if.RS2E), 32'(e.rs2));
      chk("RDE", 32'(ex_if.RDE), 32'(e.rd));
    end
  end

  initial begin
    logic [4:0] op;
    cur = '0;
    // reset coincident with a writeback to R4, after R4 was written
    set_in(1, 0, 0, mk(5'h00, 1, 2, 3), 1, 4, 19'h0ABC); cycle();
    set_in(0, 0, 0, mk(5'h1F, 0, 0, 0), 1, 4, 19'h1111); cycle();
    set_in(1, 1, 0, mk(5'h00, 1, 4, 4), 1, 4, 19'h2222); cycle();
    set_in(0, 0, 0, mk(5'h00, 1, 4, 4), 0, 0, 19'h0);    cycle();
    // write R5 then ADD rd=3 rs1=5 rs2=0
    set_in(0, 0, 0, mk(5'h1F, 0, 0, 0), 1, 5, 19'h5);    cycle();
    set_in(0, 0, 0, mk(5'h00, 3, 5, 0), 0, 0, 19'h0);    cycle();
    // bypass: SUB rs1=7 while R7 is written
    set_in(0, 0, 0, mk(5'h01, 2, 7, 0), 1, 7, 19'h1234); cycle();
    // ADDI imm=3FF, LDB
    set_in(0, 0, 0, {10'h3FF, 5'd1, 5'h04}, 0, 0, 0);    cycle();
    set_in(0, 0, 0, mk(5'h0A, 6, 5, 0), 0, 0, 0);         cycle();
    // BEQ, two stalled cycles with new instructions, then flush+stall
    set_in(0, 0, 0, mk(5'h07, 0, 5, 7), 0, 0, 0);         cycle();
    set_in(0, 1, 0, mk(5'h09, 8, 1, 2), 1, 9, 19'h77);    cycle();
    set_in(0, 1, 0, mk(5'h03, 9, 9, 5), 0, 0, 0);         cycle();
    set_in(0, 1, 1, mk(5'h03, 9, 9, 5), 0, 0, 0);         cycle();
    // illegal opcode; r0 write ignored; out-of-range write ignored
    set_in(0, 0, 0, mk(5'h1E, 4, 1, 2), 1, 0, 19'h3333);  cycle();
    set_in(0, 0, 0, mk(5'h00, 1, 0, 9), 1, 20, 19'h4444); cycle();
    set_in(0, 0, 0, mk(5'h02, 1, 20, 9), 0, 0, 0);        cycle();
    for (int n = 0; n < 600; n++) begin
      op = ($urandom_range(0, 9) < 7) ? 5'($urandom_range(0, 11)) : 5'($urandom);
      set_in($urandom_range(0, 49) == 0, $urandom_range(0, 5) == 0, $urandom_range(0, 9) == 0,
             {15'($urandom), op}, 1'($urandom), 5'($urandom_range(0, 21)), 19'($urandom));
      cycle();
    end
    set_in(0, 0, 0, mk(5'h1F, 0, 0, 0), 0, 0, 0);
    @(negedge clk);
    @(negedge clk);
    chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
